mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares one asynchronous-read, synchronous-write memory port between instruction fetch (IF) and load/store (LS). It grants at most one access per cycle, drives the memory's read/write address, data and funct3 lines, and registers the returned data and alignment error into per-requester response slots. LS has priority. A starvation counter guarantees IF forward progress. It sits between the fetch/LSU stages and a unified byte-addressable memory whose `error[1:0]` output is `{store_misaligned, load_misaligned}`.

## Interface
- `MEM_WIDTH`, 15: byte-address width.
- `MLEN`, 32: data width in bits.
- `STARVE_LIMIT`, 4: consecutive IF losses (minimum 1) that force an IF grant.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req_valid`  in  1  fetch request.
- `if_req_addr`  in  MEM_WIDTH  fetch byte address.
- `if_req_ready`  out  1  fetch grant (combinational).
- `if_rsp_valid`  out  1  fetch response slot full.
- `if_rsp_data`  out  MLEN  fetched word.
- `if_rsp_error`  out  1  fetch misaligned.
- `if_rsp_ready`  in  1  fetch consumer accepts response.
- `ls_req_valid`  in  1  load/store request.
- `ls_req_we`  in  1  1 = store, 0 = load.
- `ls_req_addr`  in  MEM_WIDTH  byte address.
- `ls_req_wdata`  in  MLEN  store data.
- `ls_req_funct3`  in  3  RV32I size/sign field.
- `ls_req_ready`  out  1  LS grant (combinational).
- `ls_rsp_valid`  out  1  LS response slot full.
- `ls_rsp_data`  out  MLEN  load data; 0 for stores.
- `ls_rsp_error`  out  1  misaligned access.
- `ls_rsp_ready`  in  1  LS consumer accepts response.
- `mem_rd_addr`, `mem_wr_addr`  out  MEM_WIDTH  memory addresses.
- `mem_wr_data`  out  MLEN  memory write data.
- `mem_wr_en`  out  1  memory write strobe.
- `mem_funct3`  out  3  memory access size.
- `mem_rd_data`  in  MLEN  combinational read data.
- `mem_error`  in  2  `{store_misaligned, load_misaligned}`.

## Operation
- **Eligibility.** A requester X is eligible when `X_req_valid` is high and its slot can take a new response: `!X_rsp_valid || X_rsp_ready`.
- **Arbitration**, evaluated every cycle:
  - Force IF when `starve_cnt == STARVE_LIMIT` and IF is eligible.
  - Otherwise LS wins if eligible, else IF wins if eligible, else nothing is granted.
  - Exactly one of `if_req_ready` and `ls_req_ready` is high per cycle, or neither.
  - Both readies are forced to 0 while `rst` is high.
- **Starvation counter.**
  - Increments, saturating at `STARVE_LIMIT`, when IF is eligible and LS is granted.
  - Clears on an IF grant.
  - Clears when `if_req_valid` is low.
  - Holds otherwise.
- **IF grant.**
  - `mem_rd_addr = if_req_addr`, `mem_funct3 = 3'b010`, `mem_wr_en = 0`.
  - Next edge: `if_rsp_data <= mem_rd_data`, `if_rsp_error <= mem_error[0]`, `if_rsp_valid <= 1`.
- **LS load grant.**
  - `mem_rd_addr = ls_req_addr`, `mem_funct3 = ls_req_funct3`.
  - Next edge: `ls_rsp_data <= mem_rd_data`, `ls_rsp_error <= mem_error[0]`.
- **LS store grant.**
  - `mem_wr_addr = ls_req_addr`, `mem_wr_data = ls_req_wdata`, `mem_wr_en = 1`, `mem_funct3 = ls_req_funct3`.
  - Next edge: `ls_rsp_data <= 0`, `ls_rsp_error <= mem_error[1]`.
  - The memory itself suppresses misaligned writes; the arbiter only reports the error.
- **Idle.** With no grant, all `mem_*` address/data outputs are 0, `mem_funct3 = 3'b010` and `mem_wr_en = 0`.
- **Response slots.**
  - `X_rsp_valid` clears when `X_rsp_ready` is high and no new X grant occurs in that cycle.
  - If a new grant and `X_rsp_ready` coincide, the slot reloads and stays valid.
  - Data and error are held stable while the slot is valid and unaccepted.

## Timing
- **Reset values.** While `rst` is high, and on the first edge after it:
  - `if_rsp_valid`, `ls_rsp_valid`, `if_rsp_error`, `ls_rsp_error` = 0.
  - `if_rsp_data`, `ls_rsp_data` = 0.
  - `starve_cnt` = 0.
  - `mem_wr_en` = 0.
- **Latency.** A request granted in cycle N has its response valid in cycle N+1; there are no other wait states.
- **Throughput.** One access per cycle. Sustained back-to-back throughput per requester is 1/cycle when its consumer holds `rsp_ready` high.
- **Simultaneous requests.** Both requesters valid:
  - LS is granted for up to `STARVE_LIMIT` cycles.
  - IF is then granted in the next cycle.
  - The counter clears and the pattern repeats.
- **Backpressure.** A full, unaccepted slot blocks only that requester. The other requester may still be granted, and its grant does not increment `starve_cnt` if IF is ineligible.
- **Reset mid-operation.**
  - Pending responses are dropped.
  - A store presented in a reset cycle is never written (`mem_wr_en` is gated by `rst`).
- **Combinational paths.** The path from request valid to ready is combinational. No path exists from `mem_rd_data` to any output.

## Test plan
- **Reset.** Assert `rst` for 3 cycles with both requests valid -> both readies stay 0, `mem_wr_en` stays 0, and after release both `rsp_valid` are 0.
- **Basic fetch.** IF-only request at 0x0010 with memory word 0xDEADBEEF -> `if_req_ready = 1` in cycle N; `if_rsp_valid = 1`, `if_rsp_data = 0xDEADBEEF`, `if_rsp_error = 0` in N+1.
- **Contention.** `STARVE_LIMIT = 4`, both requesters valid continuously, both rsp_ready high -> grant pattern is LS, LS, LS, LS, IF, repeating.
- **Store then load.** Store `sw` 0x12345678 to 0x0020, then load `lw` from 0x0020 -> `mem_wr_en` pulses for 1 cycle; the load response returns 0x12345678; the store response has `ls_rsp_data = 0`, `ls_rsp_error = 0`.
- **Misaligned accesses.** Store `sh` (funct3 001) to 0x0021 -> `ls_rsp_error = 1` on the store response. Load `lw` from 0x0022 -> `ls_rsp_error = 1`.
- **Backpressure.** Hold `if_rsp_ready = 0` with IF and LS both valid -> after one IF grant, `if_req_ready` stays 0, LS keeps being granted every cycle, and `if_rsp_data` stays stable. Release `if_rsp_ready` -> the next IF grant occurs in the same cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one asynchronous-read / synchronous-write memory port between
// instruction fetch (IF) and load/store (LS). At most one access is granted
// per cycle. LS has priority, and a starvation counter forces an IF grant
// after STARVE_LIMIT consecutive IF losses. Returned data and alignment
// errors are captured into one response slot per requester.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req_* / if_rsp_*            fetch request (valid/addr/ready) and response slot
//   ls_req_* / ls_rsp_*            load/store request and response slot
//   mem_rd_addr, mem_wr_addr       memory addresses
//   mem_wr_data, mem_wr_en         memory write data and strobe
//   mem_funct3                     access size for the memory
//   mem_rd_data, mem_error         combinational read data, {store_mis, load_mis}
module mem_port_arbiter #(
    parameter int unsigned MEM_WIDTH    = 15,
    parameter int unsigned MLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req_valid,
    input  logic [MEM_WIDTH-1:0] if_req_addr,
    output logic                 if_req_ready,
    output logic                 if_rsp_valid,
    output logic [MLEN-1:0]      if_rsp_data,
    output logic                 if_rsp_error,
    input  logic                 if_rsp_ready,
    input  logic                 ls_req_valid,
    input  logic                 ls_req_we,
    input  logic [MEM_WIDTH-1:0] ls_req_addr,
    input  logic [MLEN-1:0]      ls_req_wdata,
    input  logic [2:0]           ls_req_funct3,
    output logic                 ls_req_ready,
    output logic                 ls_rsp_valid,
    output logic [MLEN-1:0]      ls_rsp_data,
    output logic                 ls_rsp_error,
    input  logic                 ls_rsp_ready,
    output logic [MEM_WIDTH-1:0] mem_rd_addr,
    output logic [MEM_WIDTH-1:0] mem_wr_addr,
    output logic [MLEN-1:0]      mem_wr_data,
    output logic                 mem_wr_en,
    output logic [2:0]           mem_funct3,
    input  logic [MLEN-1:0]      mem_rd_data,
    input  logic [1:0]           mem_error
);

    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic            if_elig, ls_elig, force_if, if_gnt, ls_gnt;
    logic [CntW-1:0] starve_cnt_d, starve_cnt_q;
    logic            if_rsp_valid_d, if_rsp_valid_q;
    logic [MLEN-1:0] if_rsp_data_d, if_rsp_data_q;
    logic            if_rsp_error_d, if_rsp_error_q;
    logic            ls_rsp_valid_d, ls_rsp_valid_q;
    logic [MLEN-1:0] ls_rsp_data_d, ls_rsp_data_q;
    logic            ls_rsp_error_d, ls_rsp_error_q;

    // A requester may only be granted if its slot is free or being drained this cycle.
    always_comb begin
        if_elig  = if_req_valid && (!if_rsp_valid_q || if_rsp_ready);
        ls_elig  = ls_req_valid && (!ls_rsp_valid_q || ls_rsp_ready);
        force_if = (starve_cnt_q == Limit) && if_elig;
        if_gnt   = !rst && (force_if || (if_elig && !ls_elig));
        ls_gnt   = !rst && ls_elig && !force_if;
    end

    assign if_req_ready = if_gnt;
    assign ls_req_ready = ls_gnt;

    // Memory port drive; idle values keep the port quiet when nothing is granted.
    always_comb begin
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;
        mem_funct3  = 3'b010;
        if (ls_gnt) begin
            mem_funct3 = ls_req_funct3;
            if (ls_req_we) begin
                mem_wr_addr = ls_req_addr;
                mem_wr_data = ls_req_wdata;
                mem_wr_en   = 1'b1;
            end else begin
                mem_rd_addr = ls_req_addr;
            end
        end else if (if_gnt) begin
            mem_rd_addr = if_req_addr;
        end
    end

    // Counts consecutive cycles an eligible IF lost to LS; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt || !if_req_valid) begin
            starve_cnt_d = '0;
        end else if (if_elig && ls_gnt && (starve_cnt_q != Limit)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    always_comb begin
        if_rsp_valid_d = if_rsp_valid_q;
        if_rsp_data_d  = if_rsp_data_q;
        if_rsp_error_d = if_rsp_error_q;
        if (if_gnt) begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = mem_rd_data;
            if_rsp_error_d = mem_error[0];
        end else if (if_rsp_ready) begin
            if_rsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        ls_rsp_valid_d = ls_rsp_valid_q;
        ls_rsp_data_d  = ls_rsp_data_q;
        ls_rsp_error_d = ls_rsp_error_q;
        if (ls_gnt) begin
            ls_rsp_valid_d = 1'b1;
            // Stores return zero data and report the store-misaligned flag.
            ls_rsp_data_d  = ls_req_we ? '0 : mem_rd_data;
            ls_rsp_error_d = ls_req_we ? mem_error[1] : mem_error[0];
        end else if (ls_rsp_ready) begin
            ls_rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q   <= '0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            if_rsp_error_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_data_q  <= '0;
            ls_rsp_error_q <= 1'b0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            if_rsp_error_q <= if_rsp_error_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            ls_rsp_data_q  <= ls_rsp_data_d;
            ls_rsp_error_q <= ls_rsp_error_d;
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign if_rsp_error = if_rsp_error_q;
    assign ls_rsp_valid = ls_rsp_valid_q;
    assign ls_rsp_data  = ls_rsp_data_q;
    assign ls_rsp_error = ls_rsp_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a word-array memory model sits on the port,
// a scoreboard queues the expected response at each grant and a monitor
// compares it one cycle later; scenario tasks check grants and port drive.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_error, if_rsp_ready;
    logic [14:0] if_req_addr;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid, ls_req_we, ls_req_ready, ls_rsp_valid, ls_rsp_error, ls_rsp_ready;
    logic [14:0] ls_req_addr;
    logic [31:0] ls_req_wdata, ls_rsp_data;
    logic [2:0]  ls_req_funct3;
    logic [14:0] mem_rd_addr, mem_wr_addr;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_error;

    int nchecks = 0;
    int nerrors = 0;

    logic [31:0] mem     [0:255];  // memory device contents
    logic [31:0] exp_mem [0:255];  // contents the bench expects, from its own stimulus
    logic [32:0] if_q[$];
    logic [32:0] ls_q[$];

    mem_port_arbiter #(.MEM_WIDTH(15), .MLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_error(if_rsp_error),
        .if_rsp_ready(if_rsp_ready),
        .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
        .ls_req_wdata(ls_req_wdata), .ls_req_funct3(ls_req_funct3), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_error(ls_rsp_error),
        .ls_rsp_ready(ls_rsp_ready),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_rd_data(mem_rd_data),
        .mem_error(mem_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic misal(input logic [2:0] f3, input logic [14:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return |a[1:0];
            default: return 1'b0;
        endcase
    endfunction

    // Memory device: async read, sync write, misaligned writes suppressed.
    assign mem_rd_data = mem[mem_rd_addr[9:2]];
    assign mem_error   = {mem_wr_en & misal(mem_funct3, mem_wr_addr),
                          ~mem_wr_en & misal(mem_funct3, mem_rd_addr)};
    always @(posedge clk) begin
        if (mem_wr_en && !misal(mem_funct3, mem_wr_addr)) mem[mem_wr_addr[9:2]] <= mem_wr_data;
    end

    // Scoreboard producer: record expected responses at each grant.
    logic        m_skip, m_if_pend, m_ls_pend, m_if_acc, m_ls_acc;
    logic        m_if_pv, m_ls_pv, m_if_pe, m_ls_pe;
    logic [31:0] m_if_pd, m_ls_pd;
    always @(negedge clk) begin
        m_skip    = rst;
        m_if_pend = !rst && if_req_ready;
        m_ls_pend = !rst && ls_req_ready;
        m_if_acc  = if_rsp_valid && if_rsp_ready;
        m_ls_acc  = ls_rsp_valid && ls_rsp_ready;
        m_if_pv = if_rsp_valid; m_if_pd = if_rsp_data; m_if_pe = if_rsp_error;
        m_ls_pv = ls_rsp_valid; m_ls_pd = ls_rsp_data; m_ls_pe = ls_rsp_error;
        if (m_if_pend) if_q.push_back({misal(3'b010, if_req_addr), exp_mem[if_req_addr[9:2]]});
        if (m_ls_pend) begin
            if (ls_req_we) begin
                ls_q.push_back({misal(ls_req_funct3, ls_req_addr), 32'h0});
                if (!misal(ls_req_funct3, ls_req_addr)) exp_mem[ls_req_addr[9:2]] = ls_req_wdata;
            end else begin
                ls_q.push_back({misal(ls_req_funct3, ls_req_addr), exp_mem[ls_req_addr[9:2]]});
            end
        end
    end

    // Scoreboard consumer: check each slot one edge after the grant (or its clear/hold).
    always @(posedge clk) begin
        logic [32:0] e;
        #1;
        if (!m_skip) begin
            nchecks++;
            if (m_if_pend) begin
                if (if_q.size() == 0) begin
                    nerrors++; $display("FAIL if_sb_empty: grant seen with no expected entry");
                end else begin
                    e = if_q.pop_front();
                    if (if_rsp_valid !== 1'b1 || {if_rsp_error, if_rsp_data} !== e) begin
                        nerrors++;
                        $display("FAIL if_rsp: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                                 if_rsp_valid, if_rsp_error, if_rsp_data, e[32], e[31:0]);
                    end
                end
            end else if (m_if_acc) begin
                if (if_rsp_valid !== 1'b0) begin
                    nerrors++; $display("FAIL if_rsp_clear: got v=%b want 0", if_rsp_valid);
                end
            end else if (if_rsp_valid !== m_if_pv || if_rsp_data !== m_if_pd ||
                         if_rsp_error !== m_if_pe) begin
                nerrors++;
                $display("FAIL if_rsp_hold: got v=%b d=%h e=%b want v=%b d=%h e=%b",
                         if_rsp_valid, if_rsp_data, if_rsp_error, m_if_pv, m_if_pd, m_if_pe);
            end
            nchecks++;
            if (m_ls_pend) begin
                if (ls_q.size() == 0) begin
                    nerrors++; $display("FAIL ls_sb_empty: grant seen with no expected entry");
                end else begin
                    e = ls_q.pop_front();
                    if (ls_rsp_valid !== 1'b1 || {ls_rsp_error, ls_rsp_data} !== e) begin
                        nerrors++;
                        $display("FAIL ls_rsp: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                                 ls_rsp_valid, ls_rsp_error, ls_rsp_data, e[32], e[31:0]);
                    end
                end
            end else if (m_ls_acc) begin
                if (ls_rsp_valid !== 1'b0) begin
                    nerrors++; $display("FAIL ls_rsp_clear: got v=%b want 0", ls_rsp_valid);
                end
            end else if (ls_rsp_valid !== m_ls_pv || ls_rsp_data !== m_ls_pd ||
                         ls_rsp_error !== m_ls_pe) begin
                nerrors++;
                $display("FAIL ls_rsp_hold: got v=%b d=%h e=%b want v=%b d=%h e=%b",
                         ls_rsp_valid, ls_rsp_data, ls_rsp_error, m_ls_pv, m_ls_pd, m_ls_pe);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_req_we = 1'b0;
        if_rsp_ready = 1'b1; ls_rsp_ready = 1'b1;
        cyc(); cyc();
    endtask

    task automatic ls_set(input logic we, input logic [14:0] a, input logic [31:0] d,
                          input logic [2:0] f3);
        ls_req_valid = 1'b1; ls_req_we = we; ls_req_addr = a; ls_req_wdata = d;
        ls_req_funct3 = f3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 15'h0010; if_rsp_ready = 1'b1;
        ls_set(1'b1, 15'h0040, 32'hAAAA5555, 3'b010); ls_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nchecks++;
            if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b0 || mem_wr_en !== 1'b0) begin
                nerrors++;
                $display("FAIL reset_quiet: got ifr=%b lsr=%b we=%b want 0 0 0",
                         if_req_ready, ls_req_ready, mem_wr_en);
            end
            cyc();
        end
        rst = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0;
        #1;
        nchecks++;
        if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0 ||
            ls_rsp_data !== 32'h0 || if_rsp_error !== 1'b0 || ls_rsp_error !== 1'b0) begin
            nerrors++;
            $display("FAIL reset_slots: got ifv=%b lsv=%b ifd=%h lsd=%h want all 0",
                     if_rsp_valid, ls_rsp_valid, if_rsp_data, ls_rsp_data);
        end
        cyc();
    endtask

    task automatic test_basic_fetch();
        if_req_valid = 1'b1; if_req_addr = 15'h0010;
        #1;
        nchecks++;
        if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0 || mem_rd_addr !== 15'h0010 ||
            mem_funct3 !== 3'b010 || mem_wr_en !== 1'b0) begin
            nerrors++;
            $display("FAIL fetch_grant: got ifr=%b lsr=%b ra=%h f3=%b we=%b want 1 0 0010 010 0",
                     if_req_ready, ls_req_ready, mem_rd_addr, mem_funct3, mem_wr_en);
        end
        cyc();
        // Back-to-back misaligned fetch reloads the slot while it is being accepted.
        if_req_addr = 15'h0012;
        #1;
        nchecks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hDEADBEEF || if_rsp_error !== 1'b0 ||
            if_req_ready !== 1'b1) begin
            nerrors++;
            $display("FAIL fetch_rsp: got v=%b d=%h e=%b ifr=%b want 1 deadbeef 0 1",
                     if_rsp_valid, if_rsp_data, if_rsp_error, if_req_ready);
        end
        cyc();
        if_req_valid = 1'b0;
        #1;
        nchecks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_error !== 1'b1) begin
            nerrors++;
            $display("FAIL fetch_misaligned: got v=%b e=%b want 1 1", if_rsp_valid, if_rsp_error);
        end
        drain();
    endtask

    task automatic test_contention();
        logic exp_if;
        if_req_valid = 1'b1; if_req_addr = 15'h0010;
        ls_set(1'b0, 15'h0014, 32'h0, 3'b010);
        for (int i = 0; i < 10; i++) begin
            exp_if = (i % 5 == 4);
            #1;
            nchecks++;
            if (if_req_ready !== exp_if || ls_req_ready !== !exp_if) begin
                nerrors++;
                $display("FAIL contention_c%0d: got ifr=%b lsr=%b want %b %b",
                         i, if_req_ready, ls_req_ready, exp_if, !exp_if);
            end
            cyc();
        end
        drain();
    endtask

    task automatic test_store_load();
        ls_set(1'b1, 15'h0020, 32'h12345678, 3'b010);
        #1;
        nchecks++;
        if (ls_req_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_wr_addr !== 15'h0020 ||
            mem_wr_data !== 32'h12345678 || mem_funct3 !== 3'b010) begin
            nerrors++;
            $display("FAIL store_drive: got lsr=%b we=%b wa=%h wd=%h f3=%b",
                     ls_req_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_funct3);
        end
        cyc();
        ls_set(1'b0, 15'h0020, 32'h0, 3'b010);
        #1;
        nchecks++;
        if (mem_wr_en !== 1'b0 || mem_rd_addr !== 15'h0020 || ls_rsp_valid !== 1'b1 ||
            ls_rsp_data !== 32'h0 || ls_rsp_error !== 1'b0) begin
            nerrors++;
            $display("FAIL store_rsp: got we=%b ra=%h v=%b d=%h e=%b want 0 0020 1 0 0",
                     mem_wr_en, mem_rd_addr, ls_rsp_valid, ls_rsp_data, ls_rsp_error);
        end
        cyc();
        ls_req_valid = 1'b0;
        #1;
        nchecks++;
        if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'h12345678 || ls_rsp_error !== 1'b0) begin
            nerrors++;
            $display("FAIL load_rsp: got v=%b d=%h e=%b want 1 12345678 0",
                     ls_rsp_valid, ls_rsp_data, ls_rsp_error);
        end
        drain();
    endtask

    task automatic test_misaligned();
        ls_set(1'b1, 15'h0021, 32'hFFFF0000, 3'b001);
        cyc();
        ls_set(1'b0, 15'h0022, 32'h0, 3'b010);
        #1;
        nchecks++;
        if (ls_rsp_error !== 1'b1 || ls_rsp_data !== 32'h0) begin
            nerrors++;
            $display("FAIL sh_misaligned: got e=%b d=%h want 1 0", ls_rsp_error, ls_rsp_data);
        end
        cyc();
        ls_set(1'b0, 15'h0020, 32'h0, 3'b010);
        #1;
        nchecks++;
        if (ls_rsp_error !== 1'b1) begin
            nerrors++; $display("FAIL lw_misaligned: got e=%b want 1", ls_rsp_error);
        end
        cyc();
        ls_req_valid = 1'b0;
        #1;
        nchecks++;
        if (ls_rsp_error !== 1'b0 || ls_rsp_data !== 32'h12345678) begin
            nerrors++;
            $display("FAIL lw_after_sh: got e=%b d=%h want 0 12345678", ls_rsp_error, ls_rsp_data);
        end
        drain();
    endtask

    task automatic test_backpressure();
        if_rsp_ready = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 15'h0010;
        ls_set(1'b0, 15'h0020, 32'h0, 3'b010);
        for (int i = 0; i < 5; i++) begin
            #1;
            nchecks++;
            if (if_req_ready !== (i == 4) || ls_req_ready !== (i != 4)) begin
                nerrors++;
                $display("FAIL bp_first_c%0d: got ifr=%b lsr=%b", i, if_req_ready, ls_req_ready);
            end
            cyc();
        end
        if_req_addr = 15'h0024;
        for (int i = 0; i < 6; i++) begin
            #1;
            nchecks++;
            if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b1 || if_rsp_valid !== 1'b1 ||
                if_rsp_data !== 32'hDEADBEEF) begin
                nerrors++;
                $display("FAIL bp_stall_c%0d: got ifr=%b lsr=%b v=%b d=%h want 0 1 1 deadbeef",
                         i, if_req_ready, ls_req_ready, if_rsp_valid, if_rsp_data);
            end
            cyc();
        end
        if_rsp_ready = 1'b1; ls_req_valid = 1'b0;
        #1;
        nchecks++;
        if (if_req_ready !== 1'b1) begin
            nerrors++; $display("FAIL bp_release: got ifr=%b want 1", if_req_ready);
        end
        cyc();
        if_req_valid = 1'b0;
        #1;
        nchecks++;
        if (if_rsp_data !== 32'hCAFEF00D) begin
            nerrors++; $display("FAIL bp_new_rsp: got d=%h want cafef00d", if_rsp_data);
        end
        drain();
    endtask

    task automatic test_reset_midop();
        if_rsp_ready = 1'b0; if_req_valid = 1'b1; if_req_addr = 15'h0010;
        cyc();
        if_req_valid = 1'b0;
        rst = 1'b1;
        ls_set(1'b1, 15'h0030, 32'hBAD0BAD0, 3'b010);
        #1;
        nchecks++;
        if (ls_req_ready !== 1'b0 || mem_wr_en !== 1'b0) begin
            nerrors++;
            $display("FAIL midreset_quiet: got lsr=%b we=%b want 0 0", ls_req_ready, mem_wr_en);
        end
        cyc();
        rst = 1'b0; ls_req_valid = 1'b0; if_rsp_ready = 1'b1;
        #1;
        nchecks++;
        if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL midreset_drop: got ifv=%b lsv=%b want 0 0", if_rsp_valid, ls_rsp_valid);
        end
        cyc();
        ls_set(1'b0, 15'h0030, 32'h0, 3'b010);
        cyc();
        ls_req_valid = 1'b0;
        #1;
        nchecks++;
        if (ls_rsp_data !== 32'h1000000C) begin
            nerrors++; $display("FAIL midreset_nowrite: got d=%h want 1000000c", ls_rsp_data);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h10000000 + 32'(i);
            exp_mem[i] = 32'h10000000 + 32'(i);
        end
        mem[4] = 32'hDEADBEEF; exp_mem[4] = 32'hDEADBEEF;
        mem[9] = 32'hCAFEF00D; exp_mem[9] = 32'hCAFEF00D;
        if_req_addr = '0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_funct3 = 3'b010;
        ls_req_we = 1'b0;
        test_reset();
        test_basic_fetch();
        test_contention();
        test_store_load();
        test_misaligned();
        test_backpressure();
        test_reset_midop();
        nchecks++;
        if (if_q.size() != 0 || ls_q.size() != 0) begin
            nerrors++;
            $display("FAIL sb_leftover: got if=%0d ls=%0d entries want 0 0",
                     if_q.size(), ls_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
